// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: keypad FSM states, board cell encodings and
// the press classifier used by the keypad scanner.
package ttt_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } kp_state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b11;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam int         NUM_CELLS  = 9;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } press_cls_t;

  typedef struct packed {
    press_cls_t cls;
    logic [3:0] idx;
  } press_t;

  function automatic logic [3:0] cell_index(input logic [1:0] row, input int col);
    return 4'(3) * {2'b00, row} + 4'(col);
  endfunction

  // idx is only meaningful when cls is CLS_SINGLE.
  function automatic press_t classify(input logic [NUM_CELLS-1:0] v);
    press_t r;
    int     n;
    n     = 0;
    r.idx = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (v[i]) begin
        n++;
        r.idx = 4'(i);
      end
    end
    r.cls = (n == 0) ? CLS_NONE : (n == 1) ? CLS_SINGLE : CLS_MULTI;
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchronizer with a synchronous active-low
// reset to a configurable idle value.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: flops take non-blocking assignments so every register samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 3x3 active-low keypad, debounces whole scan passes and issues
// single-cycle cell-select or reject pulses to the game controller.
module keypad_scanner
  import ttt_pkg::*;
#(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        enable,
  input  logic [17:0] gBoard,
  input  logic [2:0]  colSense,
  output logic [2:0]  rowDrive,
  output logic        playerWrite,
  output logic [3:0]  playerInput,
  output logic        rejected
);

  localparam int               CYC_W    = $clog2(SCAN_CYCLES);
  localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [2:0] col_sync;

  sync2 #(
    .WIDTH    (3),
    .RESET_VAL(3'b111)
  ) u_col_sync (
    .clk  (ph1),
    .rst_n(reset),
    .d_i  (colSense),
    .q_o  (col_sync)
  );

  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [1:0]           slot_q, slot_d;
  logic [2:0]           row_q, row_d;
  logic [NUM_CELLS-1:0] pressed_q, pressed_d, pressed_full;
  logic                 slot_end, eval;
  press_t               press;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    slot_end = (cyc_q == CYC_LAST);
    eval     = slot_end && (slot_q == 2'd2);
    cyc_d    = slot_end ? '0 : cyc_q + 1'b1;
    slot_d   = slot_q;
    if (slot_end) slot_d = eval ? 2'd0 : slot_q + 2'd1;
    row_d    = ~(3'b001 << slot_d);

    // The eval cycle classifies the pass including the row-2 sample taken now.
    pressed_full = pressed_q;
    if (slot_end) begin
      for (int c = 0; c < 3; c++) begin
        if (!col_sync[c]) pressed_full[cell_index(slot_q, c)] = 1'b1;
      end
    end
    pressed_d = eval ? '0 : pressed_full;
    press     = classify(pressed_full);
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      cyc_q     <= '0;
      slot_q    <= '0;
      row_q     <= 3'b110;
      pressed_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      slot_q    <= slot_d;
      row_q     <= row_d;
      pressed_q <= pressed_d;
    end
  end

  kp_state_t        state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q, reject_q;
  logic [3:0]       input_q;
  logic             fire;
  logic [1:0]       fire_cell;

  always_comb begin
    fire = eval && (press.cls == CLS_SINGLE) &&
           (((state_q == SCAN) && (DEBOUNCE_SCANS == 1)) ||
            ((state_q == DEBOUNCE) && (press.idx == cand_q) && (cnt_q == CNT_LAST)));
    fire_cell = gBoard[{press.idx, 1'b0} +: 2];
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q  <= SCAN;
      cand_q   <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      reject_q <= 1'b0;
      input_q  <= '0;
    end else begin
      write_q  <= 1'b0;
      reject_q <= 1'b0;
      if (fire) begin
        state_q <= HELD;
        cand_q  <= press.idx;
        cnt_q   <= '0;
        if (enable) begin
          if (fire_cell == CELL_EMPTY) begin
            write_q <= 1'b1;
            input_q <= press.idx;
          end else begin
            reject_q <= 1'b1;
          end
        end
      end else if (eval) begin
        unique case (state_q)
          SCAN: begin
            if (press.cls == CLS_SINGLE) begin
              cand_q  <= press.idx;
              cnt_q   <= CNT_W'(1);
              state_q <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if ((press.cls == CLS_SINGLE) && (press.idx == cand_q)) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q   <= '0;
              state_q <= SCAN;
            end
          end
          HELD: begin
            // Release must also be stable for a full debounce window.
            if (press.cls != CLS_NONE) begin
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= SCAN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign rowDrive    = row_q;
  assign playerWrite = write_q;
  assign rejected    = reject_q;
  assign playerInput = input_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives the columns and a
// scoreboard of expected pulses is checked by a monitor on the falling edge.
module tb_keypad_scanner;
  import ttt_pkg::*;

  localparam int SC   = 4;
  localparam int DS   = 2;
  localparam int PASS = 3 * SC;

  logic        ph1;
  logic        reset;
  logic        enable;
  logic [17:0] gBoard;
  logic [2:0]  colSense;
  logic [2:0]  rowDrive;
  logic        playerWrite;
  logic [3:0]  playerInput;
  logic        rejected;

  logic [8:0]  keys;
  int          ncyc;
  int          n_checks;
  int          n_pass;
  logic [3:0]  last_input;
  int          p;

  typedef struct {
    bit         is_write;
    logic [3:0] idx;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;

  keypad_scanner #(
    .SCAN_CYCLES   (SC),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .ph1        (ph1),
    .reset      (reset),
    .enable     (enable),
    .gBoard     (gBoard),
    .colSense   (colSense),
    .rowDrive   (rowDrive),
    .playerWrite(playerWrite),
    .playerInput(playerInput),
    .rejected   (rejected)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // Cycle index since reset release; cycle 0 is slot 0, count 0.
  always @(posedge ph1) ncyc <= reset ? ncyc + 1 : 0;

  // Keypad model: a held key pulls its column low while its row is driven.
  always_comb begin
    colSense = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (keys[3*r+c] && !rowDrive[r]) colSense[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge ph1) begin
    if (playerWrite && rejected) begin
      check("write_and_reject_together", 32'(rejected), 32'(0));
    end else if (playerWrite || rejected) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, playerWrite, rejected}, 32'(0));
      end else begin
        mon_ev = sb.pop_front();
        check("pulse_kind", 32'(playerWrite), 32'(mon_ev.is_write));
        check("pulse_cycle", ncyc, mon_ev.cyc);
        if (mon_ev.is_write) begin
          check("pulse_index", 32'(playerInput), 32'(mon_ev.idx));
          last_input = mon_ev.idx;
        end else begin
          check("reject_keeps_input", 32'(playerInput), 32'(last_input));
        end
      end
    end
  end

  task automatic next();
    @(posedge ph1);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) next();
  endtask

  task automatic to_pass_start();
    for (int i = 0; i <= PASS; i++) begin
      next();
      if (ncyc % PASS == 0) return;
    end
    check("pass_align_timeout", 32'(0), 32'(1));
  endtask

  task automatic expect_pulse(input bit is_write, input logic [3:0] idx);
    ev_t e;
    e.is_write = is_write;
    e.idx      = idx;
    e.cyc      = (ncyc / PASS + DS) * PASS;
    sb.push_back(e);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    last_input = '0;
    reset      = 1'b0;
    enable     = 1'b0;
    gBoard     = '0;
    keys       = '0;

    cycles(3);
    check("reset_row", 32'(rowDrive), 32'(3'b110));
    check("reset_write", 32'(playerWrite), 32'(0));
    check("reset_reject", 32'(rejected), 32'(0));
    check("reset_input", 32'(playerInput), 32'(0));
    reset = 1'b1;
    check("row_cycle0", 32'(rowDrive), 32'(3'b110));
    cycles(4);
    check("row_cycle4", 32'(rowDrive), 32'(3'b101));
    cycles(4);
    check("row_cycle8", 32'(rowDrive), 32'(3'b011));
    cycles(4);
    check("row_cycle12", 32'(rowDrive), 32'(3'b110));
    check("idle_write", 32'(playerWrite), 32'(0));

    // Clean press of cell 5, held well past the fire point.
    enable = 1'b1;
    to_pass_start();
    keys[5] = 1'b1;
    expect_pulse(1'b1, 4'd5);
    cycles(5 * PASS);
    check("cell5_pending", sb.size(), 0);
    check("cell5_input", 32'(playerInput), 32'(5));
    keys = '0;
    cycles(3 * PASS);
    check("cell5_back_to_scan", 32'(dut.state_q), 32'(SCAN));

    // Bounced press: seen in one pass only.
    keys[5] = 1'b1;
    cycles(PASS);
    check("bounce_debounce", 32'(dut.state_q), 32'(DEBOUNCE));
    keys = '0;
    cycles(PASS);
    check("bounce_scan", 32'(dut.state_q), 32'(SCAN));

    // Two keys at once never qualify.
    keys = 9'b0_0001_0001;
    cycles(5 * PASS);
    check("multi_scan", 32'(dut.state_q), 32'(SCAN));
    keys = '0;
    cycles(PASS);
    check("multi_pending", sb.size(), 0);

    // Occupied cell 4 is rejected.
    gBoard[9:8] = CELL_P1;
    keys[4]     = 1'b1;
    expect_pulse(1'b0, 4'd4);
    cycles(3 * PASS);
    check("reject_pending", sb.size(), 0);
    keys = '0;
    cycles(3 * PASS);
    check("reject_input", 32'(playerInput), 32'(5));
    gBoard = '0;

    // Disabled turn swallows the press, then a fresh press is accepted.
    enable  = 1'b0;
    keys[2] = 1'b1;
    cycles(3 * PASS);
    check("disabled_held", 32'(dut.state_q), 32'(HELD));
    keys = '0;
    cycles(2 * PASS);
    check("disabled_released", 32'(dut.state_q), 32'(SCAN));
    enable  = 1'b1;
    keys[2] = 1'b1;
    expect_pulse(1'b1, 4'd2);
    cycles(3 * PASS);
    check("cell2_pending", sb.size(), 0);
    check("cell2_input", 32'(playerInput), 32'(2));
    keys = '0;
    cycles(3 * PASS);

    // Reset during debounce aborts the pending fire.
    keys[7] = 1'b1;
    cycles(PASS + 4);
    check("mid_debounce", 32'(dut.state_q), 32'(DEBOUNCE));
    reset = 1'b0;
    keys  = '0;
    cycles(2);
    check("rst_row", 32'(rowDrive), 32'(3'b110));
    check("rst_input", 32'(playerInput), 32'(0));
    last_input = '0;
    reset      = 1'b1;
    cycles(5 * PASS);
    check("rst_state", 32'(dut.state_q), 32'(SCAN));
    check("final_pending", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
